// File: rtl/mb_arith_seq_pkg.sv
// Shared definitions for the multi-byte arithmetic sequencer.
//   op_e    : command opcodes; also used directly as the adder operand-mux select
//   state_e : sequencer FSM encodings
package mb_arith_seq_pkg;

    localparam int LEN_W_DEF = 3;

    // Opcodes double as the adder mux select, so the two can never drift apart.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_INC = 2'd2,
        OP_DEC = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mb_arith_seq_if.sv
// Bus bundle between the control unit (master) and the sequencer (slave).
//   cmd_*  : command channel (op, length-1) with valid/ready
//   in_*   : operand byte-pair stream, LSB first, valid/ready
//   out_*  : result byte stream with last marker, valid/ready
//   done / flag_* : one-cycle completion pulse with final C/DC/Z flags
interface mb_arith_seq_if
    import mb_arith_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [LEN_W-1:0] cmd_len;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic             out_last;

    logic             done;
    logic             flag_c;
    logic             flag_dc;
    logic             flag_z;

    modport master (
        output cmd_valid, cmd_op, cmd_len, in_valid, in_a, in_b, out_ready,
        input  cmd_ready, in_ready, out_valid, out_sum, out_last,
               done, flag_c, flag_dc, flag_z
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, in_valid, in_a, in_b, out_ready,
        output cmd_ready, in_ready, out_valid, out_sum, out_last,
               done, flag_c, flag_dc, flag_z
    );

endinterface

// File: rtl/mb_arith_seq_adder8.sv
// Combinational 8-bit ALU adder shared with the CPU datapath.
//   op_a_i   : operand A
//   op_b_i   : operand B (used by ADD/SUB selects only)
//   op_mux_i : B-side select: ADD=B, SUB=~B, INC=0 with forced carry-in, DEC=0xFF
//   sub_i    : carry-in (for SUB/DEC: 1 = no borrow pending)
//   sum_o    : 8-bit result
//   c_o      : carry out of bit 7
//   dc_o     : carry out of bit 3
module mb_arith_seq_adder8
    import mb_arith_seq_pkg::*;
(
    input  logic [7:0] op_a_i,
    input  logic [7:0] op_b_i,
    input  op_e        op_mux_i,
    input  logic       sub_i,
    output logic [7:0] sum_o,
    output logic       c_o,
    output logic       dc_o
);

    logic [7:0] b_eff;
    logic       cin;
    logic [8:0] full;
    logic [4:0] nib;

    always_comb begin
        b_eff = op_b_i;
        cin   = sub_i;
        case (op_mux_i)
            OP_ADD: begin b_eff = op_b_i;  cin = sub_i; end
            OP_SUB: begin b_eff = ~op_b_i; cin = sub_i; end
            OP_INC: begin b_eff = 8'h00;   cin = 1'b1;  end
            OP_DEC: begin b_eff = 8'hFF;   cin = sub_i; end
            default: begin b_eff = op_b_i; cin = sub_i; end
        endcase
    end

    assign full  = {1'b0, op_a_i} + {1'b0, b_eff} + {8'd0, cin};
    assign nib   = {1'b0, op_a_i[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, cin};
    assign sum_o = full[7:0];
    assign c_o   = full[8];
    assign dc_o  = nib[4];

endmodule

// File: rtl/mb_arith_seq.sv
// Multi-byte add/sub/inc/dec sequencer. Takes a command, streams operand byte
// pairs LSB first through the shared adder with carry chained byte to byte,
// streams result bytes out through a one-entry output register, then pulses
// done with the final C/DC/Z flags.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of mb_arith_seq_if (cmd / in / out / done+flags)
//
//   state | meaning
//   IDLE  | waiting for a command (cmd_ready=1)
//   RUN   | accepting operand bytes, producing result bytes
//   FLUSH | last byte computed, waiting for it to be taken
//   DONE  | one-cycle done pulse with flags
module mb_arith_seq
    import mb_arith_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
)(
    input  logic          clk,
    input  logic          rst,
    mb_arith_seq_if.slave bus
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             dc_q, dc_d;
    logic             z_q, z_d;
    logic             ov_q, ov_d;
    logic [7:0]       sum_q, sum_d;
    logic             last_q, last_d;

    op_e              add_mux;
    logic [7:0]       add_b;
    logic             add_sub;
    logic [7:0]       add_sum;
    logic             add_c;
    logic             add_dc;

    logic             first;
    logic             is_last;
    logic             cmd_ready;
    logic             in_ready;
    logic             take;
    logic             beat;

    mb_arith_seq_adder8 u_adder8 (
        .op_a_i   (bus.in_a),
        .op_b_i   (add_b),
        .op_mux_i (add_mux),
        .sub_i    (add_sub),
        .sum_o    (add_sum),
        .c_o      (add_c),
        .dc_o     (add_dc)
    );

    assign first     = (cnt_q == '0);
    assign is_last   = (cnt_q == len_q);
    assign cmd_ready = (state_q == IDLE);
    // Output register frees up in the same cycle it is taken, so a take and
    // a new beat can coincide without a bubble.
    assign in_ready  = (state_q == RUN) && (!ov_q || bus.out_ready);
    assign take      = ov_q && bus.out_ready;
    assign beat      = bus.in_valid && in_ready;

    // Adder drive: the first byte seeds the chain (SUB needs carry-in 1 for
    // two's complement, INC uses the +1 select); later bytes just propagate
    // carry_q. INC becomes a plain ADD of zero after the first byte.
    always_comb begin
        add_mux = OP_ADD;
        add_b   = bus.in_b;
        add_sub = 1'b0;
        case (op_q)
            OP_ADD: begin
                add_sub = first ? 1'b0 : carry_q;
            end
            OP_SUB: begin
                add_mux = OP_SUB;
                add_sub = first ? 1'b1 : carry_q;
            end
            OP_INC: begin
                add_b = 8'h00;
                if (first) begin
                    add_mux = OP_INC;
                    add_sub = 1'b0;
                end else begin
                    add_mux = OP_ADD;
                    add_sub = carry_q;
                end
            end
            OP_DEC: begin
                add_mux = OP_DEC;
                add_b   = 8'hFF;
                add_sub = first ? 1'b0 : carry_q;
            end
            default: begin
                add_mux = OP_ADD;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        dc_d    = dc_q;
        z_d     = z_q;
        ov_d    = ov_q;
        sum_d   = sum_q;
        last_d  = last_q;

        if (take) begin
            ov_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    len_d   = bus.cmd_len;
                    cnt_d   = '0;
                    z_d     = 1'b1;
                    carry_d = 1'b0;
                    dc_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    ov_d    = 1'b1;
                    sum_d   = add_sum;
                    last_d  = is_last;
                    carry_d = add_c;
                    dc_d    = add_dc;
                    z_d     = z_q && (add_sum == 8'h00);
                    // Counter stops at len so it can never wrap at max length.
                    if (is_last) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (take) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            len_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            dc_q    <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            sum_q   <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            dc_q    <= dc_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_last  = last_q;
    assign bus.done      = (state_q == DONE);
    // Flags are only meaningful alongside done; held low otherwise.
    assign bus.flag_c    = (state_q == DONE) && carry_q;
    assign bus.flag_dc   = (state_q == DONE) && dc_q;
    assign bus.flag_z    = (state_q == DONE) && z_q;

endmodule

// File: tb/tb_mb_arith_seq.sv
// Scoreboard bench for mb_arith_seq: stimulus pushes expected result bytes and
// flags into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_mb_arith_seq;
    import mb_arith_seq_pkg::*;

    typedef struct packed {
        logic [7:0] sum;
        logic       last;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   last_take_cyc;
    logic prev_done;

    exp_t       exp_q[$];
    logic [2:0] flg_q[$];

    mb_arith_seq_if #(.LEN_W(3)) bus ();

    mb_arith_seq #(.LEN_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t       e;
        logic [2:0] f;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none", bus.out_sum);
                    end else begin
                        e = exp_q[0];
                        check("out_sum", {24'd0, bus.out_sum}, {24'd0, e.sum});
                        if (bus.out_ready) begin
                            check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
                            void'(exp_q.pop_front());
                            if (e.last) last_take_cyc = cyc;
                        end else begin
                            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                        end
                    end
                end
                if (bus.done) begin
                    check("done_width", {31'd0, prev_done}, 32'd0);
                    if (flg_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got 1 expected 0");
                    end else begin
                        f = flg_q.pop_front();
                        check("flags_c_dc_z",
                              {29'd0, bus.flag_c, bus.flag_dc, bus.flag_z}, {29'd0, f});
                        check("done_latency", cyc, last_take_cyc + 1);
                    end
                end
                prev_done = bus.done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // Drivers: called at posedge+1, leave at posedge+1.
    task automatic send_cmd(input op_e op, input logic [2:0] len);
        int   n;
        logic ok;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        do begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) fail_now("cmd_handshake");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        int   n;
        logic ok;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) fail_now("in_handshake");
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input op_e op, input logic [2:0] len,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] res, input logic [2:0] flags);
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back({res[8*i +: 8], (i == int'(len))});
        flg_q.push_back(flags);
        send_cmd(op, len);
        for (int i = 0; i <= int'(len); i++)
            send_beat(a[8*i +: 8], b[8*i +: 8]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || flg_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_bytes", exp_q.size(), 0);
        check("drain_flags", flg_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        last_take_cyc = -10;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_ADD;
        bus.cmd_len   = 3'd0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_sum",   {24'd0, bus.out_sum},   32'd0);
        check("rst_done",      {31'd0, bus.done},      32'd0);
        check("rst_flags",     {29'd0, bus.flag_c, bus.flag_dc, bus.flag_z}, 32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // flags packed as {C, DC, Z}
        run_op(OP_ADD, 3'd1, 64'h12FF, 64'h0001, 64'h1300, 3'b000);
        run_op(OP_SUB, 3'd1, 64'h0100, 64'h0001, 64'h00FF, 3'b110);
        run_op(OP_INC, 3'd2, 64'hFFFFFF, 64'h0, 64'h000000, 3'b111);
        run_op(OP_DEC, 3'd0, 64'h00, 64'h0, 64'hFF, 3'b000);
        run_op(OP_INC, 3'd1, 64'h12FE, 64'h0, 64'h12FF, 3'b000);
        run_op(OP_DEC, 3'd1, 64'h0100, 64'h0, 64'h00FF, 3'b110);
        run_op(OP_SUB, 3'd0, 64'h00, 64'h01, 64'hFF, 3'b000);
        run_op(OP_ADD, 3'd7, 64'hFFFFFFFFFFFFFFFF, 64'h01, 64'h0, 3'b111);
        drain();

        // Backpressure mid-ADD: consumer stalls 3 clocks.
        fork
            run_op(OP_ADD, 3'd3, 64'h11223344, 64'h01020304, 64'h12243648, 3'b000);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset during RUN with one result byte held.
        exp_q.push_back({8'h48, 1'b0});
        bus.out_ready = 1'b0;
        send_cmd(OP_ADD, 3'd3);
        send_beat(8'h44, 8'h04);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstrun_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rstrun_done",      {31'd0, bus.done},      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        flg_q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rstrun_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rstrun_out_valid2", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        run_op(OP_SUB, 3'd1, 64'h1234, 64'h0234, 64'h1000, 3'b110);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
